// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   mem_state_e : data-memory handshake FSM states (IDLE, BUSY, DONE)
//   FWD_*       : execute-stage forwarding mux selects
//   fwd_sel()   : forwarding priority (MEM stage over WB stage)
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from ALUOutM

    // Register 0 is hard-wired to zero, so it is never forwarded.
    // The younger producer (MEM) wins over the older one (WB).
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       reg_write_m,
        input logic [4:0] write_reg_m,
        input logic       reg_write_w,
        input logic [4:0] write_reg_w
    );
        if (src != 5'd0 && reg_write_m && write_reg_m == src)
            return FWD_MEM;
        else if (src != 5'd0 && reg_write_w && write_reg_w == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// -----------------------------------------------------------------------------
// mem_wait_fsm
// Variable-latency data-memory handshake. Requests memory for the instruction
// in M, freezes the pipeline until memAck or a timeout, then releases it for
// one DONE cycle in which the M instruction advances.
//   clk, rst     : clock, synchronous active-high reset
//   mem_access   : load/store occupying M
//   mem_ack      : data memory done (ignored outside BUSY)
//   mem_req      : data memory request (combinational)
//   mem_stall    : freeze pipeline (combinational)
//   mem_timeout  : sticky flag, set when BUSY ran out without an ack
// -----------------------------------------------------------------------------
module mem_wait_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7    // needs 2**CNT_W > TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_access,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_stall,
    output logic mem_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        mem_req   = 1'b0;
        mem_stall = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The request and the freeze start in the same cycle the
                // access shows up in M.
                mem_req   = mem_access;
                mem_stall = mem_access;
                if (mem_access)
                    state_d = BUSY;
            end
            BUSY: begin
                mem_req   = 1'b1;
                mem_stall = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                // Ack is checked first so a late ack on the last cycle still
                // counts as a successful access.
                if (mem_ack) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                    cnt_d     = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An access in flight is abandoned on reset; no request that cycle.
        if (rst) begin
            mem_req   = 1'b0;
            mem_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central sequencer for the 5-stage pipeline registers. Produces stall, flush
// and forwarding controls for load-use and branch-in-decode hazards, and
// freezes the pipeline while the data memory handshake is outstanding.
//   clk, rst                        : clock, synchronous active-high reset
//   rsD/rtD, rsE/rtE                : source registers in D and E
//   writeRegE/M/W, regWriteE/M/W    : destination registers and enables
//   memToRegE/M                     : load flags
//   branchD, pcSrcD                 : branch in D and its taken result
//   memAccessM, memAck              : memory access in M, memory done
//   stallF/D/E/M                    : hold PC, IF/ID, ID/EX, EX/MEM
//   flushD/E/W                      : bubble into IF/ID, ID/EX, MEM/WB
//   forwardAD/BD                    : D compare operand from ALUOutM
//   forwardAE/BE                    : E operand select (FWD_RF/WB/MEM)
//   memReq, memTimeout              : memory request, sticky timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] writeRegE,
    input  logic [4:0] writeRegM,
    input  logic [4:0] writeRegW,
    input  logic       regWriteE,
    input  logic       regWriteM,
    input  logic       regWriteW,
    input  logic       memToRegE,
    input  logic       memToRegM,
    input  logic       branchD,
    input  logic       pcSrcD,
    input  logic       memAccessM,
    input  logic       memAck,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushW,
    output logic       forwardAD,
    output logic       forwardBD,
    output logic [1:0] forwardAE,
    output logic [1:0] forwardBE,
    output logic       memReq,
    output logic       memTimeout
);

    logic mem_stall;
    logic lw_stall;
    logic br_stall;
    logic hz_stall;

    mem_wait_fsm #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_mem_wait_fsm (
        .clk         (clk),
        .rst         (rst),
        .mem_access  (memAccessM),
        .mem_ack     (memAck),
        .mem_req     (memReq),
        .mem_stall   (mem_stall),
        .mem_timeout (memTimeout)
    );

    // A load in E cannot feed D's operands until it reaches WB.
    assign lw_stall = memToRegE & (rtE == rsD | rtE == rtD);

    // The branch comparator in D needs its operands now: wait for an ALU
    // result still in E, or for a load result still in M.
    assign br_stall = branchD &
                      ((regWriteE & (writeRegE == rsD | writeRegE == rtD)) |
                       (memToRegM & (writeRegM == rsD | writeRegM == rtD)));

    assign hz_stall = lw_stall | br_stall;

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAE = FWD_RF;
        forwardBE = FWD_RF;
        forwardAD = 1'b0;
        forwardBD = 1'b0;

        if (rst) begin
            flushE = 1'b1;
            flushW = 1'b1;
        end else begin
            // The memory freeze holds every stage and masks hazard handling;
            // MEM/WB gets bubbles so WB does not repeat the frozen M result.
            if (mem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (hz_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end

            forwardAE = fwd_sel(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardBE = fwd_sel(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
            forwardAD = (rsD != 5'd0) & regWriteM & (writeRegM == rsD);
            forwardBD = (rtD != 5'd0) & regWriteM & (writeRegM == rtD);
        end

        // A taken branch squashes the fetched instruction only when D is free
        // to take the redirected one.
        flushD = pcSrcD & ~stallD & ~rst;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates stall, flush and forwarding controls for the load-use hazard and for branch-in-decode hazards.
- Runs a variable-latency data-memory handshake FSM. The FSM freezes the pipeline and inserts bubbles into MEM/WB until memory acknowledges or a timeout fires.

Parameters:
- TIMEOUT_CYCLES, 64, max BUSY cycles before forced release.
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rsD, rtD  in  5 each  source regs in decode.
- rsE, rtE  in  5 each  source regs in execute.
- writeRegE, writeRegM, writeRegW  in  5 each  destination regs.
- regWriteE, regWriteM, regWriteW  in  1 each  write enables.
- memToRegE, memToRegM  in  1 each  load flags.
- branchD  in  1  branch instruction in decode.
- pcSrcD  in  1  branch taken (resolved in D).
- memAccessM  in  1  load/store occupying M.
- memAck  in  1  data memory done.
- stallF, stallD, stallE, stallM  out  1 each  hold PC / IF/ID / ID/EX / EX/MEM.
- flushD, flushE, flushW  out  1 each  bubble into IF/ID / ID/EX / MEM/WB.
- forwardAD, forwardBD  out  1 each  D-stage compare operand from ALUOutM.
- forwardAE, forwardBE  out  2 each  00 regfile, 01 WB result, 10 ALUOutM.
- memReq  out  1  data memory request.
- memTimeout  out  1  sticky timeout flag.

Behaviour:
- Registered state: FSM state, wait counter, memTimeout. All other outputs are combinational from state and inputs.
- Reset (rst=1 at an edge): state<=IDLE, counter<=0, memTimeout<=0.
- While rst is high, outputs are forced to: all stalls 0, flushE=1, flushW=1, flushD=0, memReq=0, forwards 0.
- Reset during BUSY aborts the access; memReq is 0 in the reset cycle.

Forwarding (execute operands):
- forwardAE=10 if rsE!=0 & regWriteM & writeRegM==rsE.
- Else forwardAE=01 if rsE!=0 & regWriteW & writeRegW==rsE.
- Else forwardAE=00.
- M has priority over W. forwardBE uses rtE with the same rules.

Forwarding (decode compare):
- forwardAD = rsD!=0 & regWriteM & writeRegM==rsD. forwardBD uses rtD likewise.

Hazard stalls:
- lwStall = memToRegE & (rtE==rsD | rtE==rtD).
- brStall = branchD & ((regWriteE & (writeRegE==rsD | writeRegE==rtD)) | (memToRegM & (writeRegM==rsD | writeRegM==rtD))).
- hzStall = lwStall | brStall.

Memory FSM (states IDLE, BUSY, DONE):
- IDLE: memReq=memAccessM. If memAccessM, go to BUSY and set memStall=1. memAck is ignored in IDLE.
- BUSY: memReq=1 and memStall=1; counter increments each cycle.
  - memAck=1: go to DONE, counter<=0.
  - counter==TIMEOUT_CYCLES-1 without ack: memTimeout<=1, go to DONE, counter<=0.
  - memAck and timeout in the same cycle: ack wins, memTimeout is unchanged.
- DONE: memReq=0, memStall=0. The M instruction advances this edge. Go to IDLE.
- A back-to-back memory op in the next instruction gets a fresh request in IDLE.
- Minimum M occupancy is 3 cycles (IDLE req, BUSY ack, DONE), i.e. 2 frozen cycles.

Output composition:
- memStall=1 overrides everything:
  - stallF=stallD=stallE=stallM=1.
  - flushW=1.
  - flushE=0, flushD=0.
  - Hazard detection is masked.
- Else if hzStall: stallF=stallD=1, flushE=1, stallE=stallM=0, flushW=0.
- Else: no stalls.
- flushD = pcSrcD & ~stallD.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FSM state enum {IDLE, BUSY, DONE}.
  - Forward-select constants FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- One sub-module, mem_wait_fsm: state, counter, timeout flag, memReq, memStall.
- Forwarding and hazard logic stay in the top module.

Test Plan:
- Forwarding: rsE=5, regWriteM=1 writeRegM=5, regWriteW=1 writeRegW=5 -> forwardAE=10. Drop regWriteM -> 01. rsE=0 -> 00.
- Load-use: memToRegE=1 rtE=3, rsD=3, no mem op -> stallF=stallD=flushE=1 for exactly one cycle.
- Branch hazard: branchD=1 rsD=7, regWriteE=1 writeRegE=7 -> stallF=stallD=1, flushE=1. Next cycle with pcSrcD=1 and no hazard -> flushD=1.
- Memory wait: memAccessM=1, memAck pulsed 3 cycles after req:
  - memReq high 4 cycles.
  - stallF..stallM=1 and flushW=1 on those cycles.
  - DONE cycle: all 0.
  - memTimeout=0.
- Timeout: TIMEOUT_CYCLES=4, memAck never -> memTimeout=1 after 4 BUSY cycles; pipeline released; flag stays set until rst.
- Reset mid-BUSY: rst in 2nd BUSY cycle -> memReq=0 that cycle, flushE=flushW=1; state IDLE after the edge.
